// File: rtl/ledandkey_arbiter_if.sv
// Bundle between the two clients, the arbiter and the ledandkey driver.
// slave = arbiter side, master = clients/driver side.
interface ledandkey_arbiter_if;
  logic        a_req;
  logic [63:0] a_disp;
  logic [7:0]  a_leds;
  logic        a_grant;
  logic [7:0]  a_key_press;
  logic        b_req;
  logic [63:0] b_disp;
  logic [7:0]  b_leds;
  logic        b_grant;
  logic [7:0]  b_key_press;
  logic [7:0]  keys_raw;
  logic [63:0] disp_out;
  logic [7:0]  leds_out;
  logic [7:0]  key_state;

  modport slave (
    input  a_req, a_disp, a_leds, b_req, b_disp, b_leds, keys_raw,
    output a_grant, a_key_press, b_grant, b_key_press, disp_out, leds_out, key_state
  );

  modport master (
    output a_req, a_disp, a_leds, b_req, b_disp, b_leds, keys_raw,
    input  a_grant, a_key_press, b_grant, b_key_press, disp_out, leds_out, key_state
  );
endinterface

// File: rtl/ledandkey_arbiter.sv
// Time-sliced sharing of one TM1638 board between clients A and B; grant 1 clk, display 2 clk after request.
// No backpressure: clients poll their grant, key-press pulses go only to the owner.
module ledandkey_arbiter #(
  parameter int SAMPLE_DIV   = 1000,
  parameter int DEBOUNCE_N   = 4,
  parameter int SLICE_TICKS  = 50000000,
  parameter int OVERRIDE_KEY = 7
) (
  input  logic                 clock,
  input  logic                 reset_n,
  ledandkey_arbiter_if.slave   bus
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int SLC_W = $clog2(SLICE_TICKS);
  localparam int DEB_W = $clog2(DEBOUNCE_N + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD   = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [SLC_W-1:0] SLICE_LOAD = SLC_W'(SLICE_TICKS - 1);
  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_N - 1);
  localparam logic [2:0]       OVR_IDX    = 3'(OVERRIDE_KEY);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t           state;
  logic             last_owner_b;
  logic [SLC_W-1:0] slice_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [DEB_W-1:0] deb_cnt [8];
  logic [7:0]       key_state_q;
  logic [7:0]       key_prev;
  logic [63:0]      disp_q;
  logic [7:0]       leds_q;
  logic [7:0]       a_press_q;
  logic [7:0]       b_press_q;

  logic       a_req, b_req, tick, ovr_press, slice_done;
  logic [7:0] rise, fwd;

  assign a_req      = bus.a_req;
  assign b_req      = bus.b_req;
  assign tick       = (div_cnt == '0);
  assign rise       = key_state_q & ~key_prev;
  assign ovr_press  = rise[OVR_IDX];
  // The override key is always swallowed, even when it does not cause a swap.
  assign fwd        = rise & ~(8'b1 << OVR_IDX);
  assign slice_done = (slice_cnt == '0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      last_owner_b <= 1'b1;
      slice_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_req && (!b_req || last_owner_b)) begin
            state <= OWN_A; last_owner_b <= 1'b0; slice_cnt <= SLICE_LOAD;
          end else if (b_req) begin
            state <= OWN_B; last_owner_b <= 1'b1; slice_cnt <= SLICE_LOAD;
          end
        end
        OWN_A: begin
          if (b_req && (!a_req || ovr_press || slice_done)) begin
            state <= OWN_B; last_owner_b <= 1'b1; slice_cnt <= SLICE_LOAD;
          end else if (!a_req) begin
            state <= IDLE;
          end else if (!slice_done) begin
            slice_cnt <= slice_cnt - 1'b1;
          end
        end
        OWN_B: begin
          if (a_req && (!b_req || ovr_press || slice_done)) begin
            state <= OWN_A; last_owner_b <= 1'b0; slice_cnt <= SLICE_LOAD;
          end else if (!b_req) begin
            state <= IDLE;
          end else if (!slice_done) begin
            slice_cnt <= slice_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      disp_q      <= '0;
      leds_q      <= '0;
      a_press_q   <= '0;
      b_press_q   <= '0;
      key_state_q <= '0;
      key_prev    <= '0;
      div_cnt     <= DIV_LOAD;
      for (int i = 0; i < 8; i++) deb_cnt[i] <= '0;
    end else begin
      case (state)
        OWN_A:   begin disp_q <= bus.a_disp; leds_q <= bus.a_leds; end
        OWN_B:   begin disp_q <= bus.b_disp; leds_q <= bus.b_leds; end
        default: begin disp_q <= '0;         leds_q <= '0;         end
      endcase
      a_press_q <= (state == OWN_A) ? fwd : 8'h00;
      b_press_q <= (state == OWN_B) ? fwd : 8'h00;
      key_prev  <= key_state_q;
      div_cnt   <= tick ? DIV_LOAD : div_cnt - 1'b1;
      if (tick) begin
        for (int i = 0; i < 8; i++) begin
          if (bus.keys_raw[i] == key_state_q[i]) begin
            deb_cnt[i] <= '0;
          end else if (deb_cnt[i] == DEB_LAST) begin
            key_state_q[i] <= bus.keys_raw[i];
            deb_cnt[i]     <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign bus.a_grant     = (state == OWN_A);
  assign bus.b_grant     = (state == OWN_B);
  assign bus.disp_out    = disp_q;
  assign bus.leds_out    = leds_q;
  assign bus.a_key_press = a_press_q;
  assign bus.b_key_press = b_press_q;
  assign bus.key_state   = key_state_q;

endmodule

// File: tb/tb_ledandkey_arbiter.sv
// Directed bench for ledandkey_arbiter with SAMPLE_DIV=4, DEBOUNCE_N=3, SLICE_TICKS=20.
module tb_ledandkey_arbiter;
  logic clock;
  logic reset_n;
  ledandkey_arbiter_if bus ();

  ledandkey_arbiter #(
    .SAMPLE_DIV(4), .DEBOUNCE_N(3), .SLICE_TICKS(20), .OVERRIDE_KEY(7)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  localparam logic [63:0] A_DISP = 64'h0123_4567_89ab_cdef;
  localparam logic [63:0] B_DISP = 64'hfedc_ba98_7654_3210;
  localparam logic [7:0]  A_LEDS = 8'h5a;
  localparam logic [7:0]  B_LEDS = 8'ha5;

  int vectors = 0;
  int miscompares = 0;
  int a_ev, b_ev;
  logic [7:0] a_or, b_or, ks_or;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_ev();
    a_ev = 0; b_ev = 0; a_or = 8'h00; b_or = 8'h00; ks_or = 8'h00;
  endtask

  // Advance n cycles, sampling at negedge and accumulating key-press activity.
  task automatic watch(input int n);
    repeat (n) begin
      @(negedge clock);
      if (bus.a_key_press != 8'h00) begin a_ev++; a_or |= bus.a_key_press; end
      if (bus.b_key_press != 8'h00) begin b_ev++; b_or |= bus.b_key_press; end
      ks_or |= bus.key_state;
    end
  endtask

  initial begin
    int first;
    bit exp_a, exp_b;
    logic [63:0] exp_disp;
    logic [7:0]  exp_leds;

    reset_n = 1'b0;
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    bus.a_disp = A_DISP; bus.b_disp = B_DISP;
    bus.a_leds = A_LEDS; bus.b_leds = B_LEDS;
    bus.keys_raw = 8'h00;
    clear_ev();

    watch(3);
    chk("rst_a_grant", bus.a_grant, 0);
    chk("rst_b_grant", bus.b_grant, 0);
    chk("rst_disp", bus.disp_out, 0);
    chk("rst_leds", bus.leds_out, 0);
    chk("rst_key_state", bus.key_state, 0);
    chk("rst_press", {bus.a_key_press, bus.b_key_press}, 0);

    reset_n = 1'b1;
    watch(1);
    bus.a_req = 1'b1; bus.b_req = 1'b1;

    // Both requesting: A for 20 cycles, then B for 20, then A; data lags grant by one.
    for (int k = 1; k <= 60; k++) begin
      watch(1);
      exp_a = (((k - 1) / 20) % 2) == 0;
      exp_b = !exp_a;
      if (k == 1) begin
        exp_disp = 64'h0; exp_leds = 8'h00;
      end else begin
        exp_disp = ((((k - 2) / 20) % 2) == 0) ? A_DISP : B_DISP;
        exp_leds = ((((k - 2) / 20) % 2) == 0) ? A_LEDS : B_LEDS;
      end
      chk($sformatf("slice_a_grant[%0d]", k), bus.a_grant, exp_a);
      chk($sformatf("slice_b_grant[%0d]", k), bus.b_grant, exp_b);
      chk($sformatf("slice_disp[%0d]", k), bus.disp_out, exp_disp);
      chk($sformatf("slice_leds[%0d]", k), bus.leds_out, exp_leds);
    end

    // A drops with B idle -> IDLE, outputs blank one cycle later.
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    watch(1);
    chk("drop_grants", {bus.a_grant, bus.b_grant}, 2'b00);
    chk("drop_disp_lag", bus.disp_out, A_DISP);
    watch(1);
    chk("idle_disp", bus.disp_out, 0);
    chk("idle_leds", bus.leds_out, 0);
    bus.b_req = 1'b1;
    watch(1);
    chk("idle_to_b", {bus.a_grant, bus.b_grant}, 2'b01);

    bus.b_req = 1'b0; bus.a_req = 1'b1;
    watch(1);
    chk("b_drop_to_a", {bus.a_grant, bus.b_grant}, 2'b10);

    // Key 2 held 12 clocks -> accepted, one pulse to A only.
    clear_ev();
    bus.keys_raw = 8'h04;
    watch(12);
    chk("k2_key_state", bus.key_state, 8'h04);
    bus.keys_raw = 8'h00;
    watch(4);
    chk("k2_a_pulses", a_ev, 1);
    chk("k2_a_bits", a_or, 8'h04);
    chk("k2_b_pulses", b_ev, 0);
    clear_ev();
    watch(12);
    chk("k2_release_state", bus.key_state, 8'h00);
    chk("k2_release_events", a_ev + b_ev, 0);

    // Key 2 held only 8 clocks -> rejected.
    clear_ev();
    bus.keys_raw = 8'h04;
    watch(8);
    bus.keys_raw = 8'h00;
    watch(16);
    chk("short_key_state_seen", ks_or, 8'h00);
    chk("short_events", a_ev + b_ev, 0);

    // Fresh A slice, then B requests and override key pressed.
    bus.a_req = 1'b0;
    watch(1);
    bus.a_req = 1'b1;
    watch(1);
    chk("fresh_a", {bus.a_grant, bus.b_grant}, 2'b10);
    bus.b_req = 1'b1; bus.keys_raw = 8'h80;
    clear_ev();
    first = 0;
    for (int k = 1; k <= 14; k++) begin
      watch(1);
      if (bus.b_grant && first == 0) first = k;
    end
    chk("ovr_swap_window", (first >= 10 && first <= 13), 1'b1);
    if (first == 0) first = 14;
    watch(first + 5);
    chk("ovr_b_slice_full", {bus.a_grant, bus.b_grant}, 2'b01);
    watch(1);
    chk("ovr_b_slice_end", {bus.a_grant, bus.b_grant}, 2'b10);
    chk("ovr_consumed", {a_or[7], b_or[7]}, 2'b00);

    // Override with B idle: no swap, press still swallowed.
    bus.b_req = 1'b0; bus.keys_raw = 8'h00;
    watch(16);
    clear_ev();
    bus.keys_raw = 8'h80;
    watch(16);
    chk("ovr2_key_state", bus.key_state, 8'h80);
    chk("ovr2_no_swap", {bus.a_grant, bus.b_grant}, 2'b10);
    chk("ovr2_events", a_ev + b_ev, 0);

    // Reset mid-slice with a pending debounce count.
    bus.b_req = 1'b1; bus.keys_raw = 8'h01;
    watch(5);
    reset_n = 1'b0;
    watch(1);
    chk("mid_rst_grants", {bus.a_grant, bus.b_grant}, 2'b00);
    chk("mid_rst_disp", bus.disp_out, 0);
    chk("mid_rst_leds", bus.leds_out, 0);
    chk("mid_rst_key_state", bus.key_state, 0);
    chk("mid_rst_press", {bus.a_key_press, bus.b_key_press}, 0);
    watch(1);
    bus.keys_raw = 8'h00; bus.a_req = 1'b1; bus.b_req = 1'b1;
    reset_n = 1'b1;
    watch(1);
    chk("post_rst_a_first", {bus.a_grant, bus.b_grant}, 2'b10);
    chk("post_rst_key_state", bus.key_state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
